// File: rtl/robots_tone_synth.sv
// Multi-voice tone generator: per-voice phase accumulator, waveform and volume,
// mixed and driven out through a first-order sigma-delta modulator to one pin.
module robots_tone_synth #(
    parameter int unsigned NVOICE = 2,
    parameter int unsigned PHW    = 16,
    parameter int unsigned DURW   = 12,
    parameter int unsigned VIW    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              smp_tick,
    input  logic              ms_tick,
    input  logic              cmd_stb,
    output logic              cmd_rdy,
    input  logic [VIW-1:0]    cmd_voice,
    input  logic [PHW-1:0]    cmd_freq,
    input  logic [1:0]        cmd_mode,
    input  logic [3:0]        cmd_vol,
    input  logic [DURW-1:0]   cmd_dur,
    output logic [NVOICE-1:0] busy,
    output logic [NVOICE-1:0] done_stb,
    output logic              audio
);
    localparam int unsigned MW = 8 + $clog2(NVOICE);
    localparam int unsigned P  = PHW - 1;

    logic [PHW-1:0]  phase   [NVOICE];
    logic [PHW-1:0]  freq    [NVOICE];
    logic [1:0]      mode    [NVOICE];
    logic [3:0]      vol     [NVOICE];
    logic [DURW-1:0] dur     [NVOICE];
    logic [7:0]      smp     [NVOICE];
    logic [7:0]      smp_nxt [NVOICE];
    logic [NVOICE-1:0] hit;
    logic [MW-1:0]   mix;
    logic [MW-1:0]   mix_nxt;
    logic [MW-1:0]   acc;
    logic [MW:0]     sd_sum;

    // Commands are refused only while reset is held.
    assign cmd_rdy = ~rst;

    // Command decode plus waveform shaping and volume scaling per voice.
    always_comb begin : wave_gen
        logic [7:0]  raw;
        logic [11:0] prod;
        hit  = '0;
        raw  = 8'd0;
        prod = 12'd0;
        for (int unsigned v = 0; v < NVOICE; v++) begin
            hit[v] = cmd_stb && cmd_rdy && (32'(cmd_voice) == v);
            raw    = 8'd0;
            if (busy[v]) begin
                case (mode[v])
                    2'd0:    raw = phase[v][P] ? 8'hFF : 8'h00;
                    2'd1:    raw = phase[v][P -: 8];
                    2'd2:    raw = phase[v][P] ? ~phase[v][P-1 -: 8] : phase[v][P-1 -: 8];
                    default: raw = 8'd0;
                endcase
            end
            prod       = 12'(raw) * 12'(vol[v]);
            smp_nxt[v] = prod[11:4];
        end
    end

    // Mix is sized so the sum of all full-scale voices cannot overflow.
    always_comb begin : mixer
        mix_nxt = '0;
        for (int unsigned v = 0; v < NVOICE; v++) begin
            mix_nxt = mix_nxt + MW'(smp[v]);
        end
    end

    assign sd_sum = {1'b0, acc} + {1'b0, mix};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < NVOICE; v++) begin
                phase[v] <= '0;
                freq[v]  <= '0;
                mode[v]  <= 2'd0;
                vol[v]   <= 4'd0;
                dur[v]   <= '0;
                smp[v]   <= 8'd0;
            end
            busy     <= '0;
            done_stb <= '0;
            mix      <= '0;
            acc      <= '0;
            audio    <= 1'b0;
        end else begin
            done_stb     <= '0;
            mix          <= mix_nxt;
            {audio, acc} <= sd_sum;
            for (int unsigned v = 0; v < NVOICE; v++) begin
                smp[v] <= smp_nxt[v];
                // A command overrides any expiry landing in the same cycle.
                if (hit[v]) begin
                    freq[v]  <= cmd_freq;
                    mode[v]  <= cmd_mode;
                    vol[v]   <= cmd_vol;
                    dur[v]   <= cmd_dur;
                    phase[v] <= '0;
                    busy[v]  <= (cmd_freq != '0);
                end else if (busy[v]) begin
                    if (smp_tick) begin
                        phase[v] <= phase[v] + freq[v];
                    end
                    if (ms_tick && (dur[v] != '0)) begin
                        dur[v] <= dur[v] - DURW'(1);
                        if (dur[v] == DURW'(1)) begin
                            busy[v]     <= 1'b0;
                            done_stb[v] <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_robots_tone_synth.sv
// Bench for robots_tone_synth: a cycle model feeds a scoreboard every clock, and a
// vector table checks the sigma-delta density for hand-computed waveform samples.
module tb_robots_tone_synth;
    localparam int NV   = 2;
    localparam int PHW  = 16;
    localparam int DURW = 12;
    localparam int VIW  = 2;
    localparam int MSUM = 512;

    logic            clk = 1'b0;
    logic            rst;
    logic            smp_tick;
    logic            ms_tick;
    logic            cmd_stb;
    logic            cmd_rdy;
    logic [VIW-1:0]  cmd_voice;
    logic [PHW-1:0]  cmd_freq;
    logic [1:0]      cmd_mode;
    logic [3:0]      cmd_vol;
    logic [DURW-1:0] cmd_dur;
    logic [NV-1:0]   busy;
    logic [NV-1:0]   done_stb;
    logic            audio;

    robots_tone_synth #(.NVOICE(NV), .PHW(PHW), .DURW(DURW), .VIW(VIW)) dut (
        .clk(clk), .rst(rst), .smp_tick(smp_tick), .ms_tick(ms_tick),
        .cmd_stb(cmd_stb), .cmd_rdy(cmd_rdy), .cmd_voice(cmd_voice),
        .cmd_freq(cmd_freq), .cmd_mode(cmd_mode), .cmd_vol(cmd_vol),
        .cmd_dur(cmd_dur), .busy(busy), .done_stb(done_stb), .audio(audio)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NV-1:0] busy;
        logic [NV-1:0] done;
        logic          audio;
    } obs_t;

    typedef struct {
        int mode;
        int vol;
        int freq;
        int nticks;
        int ones;
    } vec_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done1_cnt = 0;

    // Reference model state
    int mp[NV], mf[NV], mm[NV], mvl[NV], md[NV], ms[NV];
    bit ma[NV], mdn[NV];
    int mmix = 0, macc = 0;
    bit maud = 1'b0;

    function automatic int wave_model(int mode, int ph, bit act);
        int top8 = (ph >> (PHW - 8)) & 255;
        int sub  = (ph >> (PHW - 9)) & 255;
        bit msb  = bit'((ph >> (PHW - 1)) & 1);
        if (!act) return 0;
        case (mode)
            0: return msb ? 255 : 0;
            1: return top8;
            2: return msb ? (255 - sub) : sub;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        int nmix;
        int t;
        if (rst) begin
            for (int v = 0; v < NV; v++) begin
                mp[v] = 0; mf[v] = 0; mm[v] = 0; mvl[v] = 0; md[v] = 0; ms[v] = 0;
                ma[v] = 1'b0; mdn[v] = 1'b0;
            end
            mmix = 0; macc = 0; maud = 1'b0;
        end else begin
            nmix = 0;
            for (int v = 0; v < NV; v++) nmix += ms[v];
            t    = macc + mmix;
            maud = (t >= MSUM);
            macc = t % MSUM;
            mmix = nmix;
            for (int v = 0; v < NV; v++) begin
                ms[v]  = (wave_model(mm[v], mp[v], ma[v]) * mvl[v]) / 16;
                mdn[v] = 1'b0;
                if (cmd_stb && int'(cmd_voice) == v) begin
                    mf[v] = int'(cmd_freq); mm[v] = int'(cmd_mode);
                    mvl[v] = int'(cmd_vol); md[v] = int'(cmd_dur);
                    mp[v] = 0; ma[v] = (cmd_freq != 0);
                end else if (ma[v]) begin
                    if (smp_tick) mp[v] = (mp[v] + mf[v]) % 65536;
                    if (ms_tick && md[v] != 0) begin
                        md[v]--;
                        if (md[v] == 0) begin
                            ma[v]  = 1'b0;
                            mdn[v] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // One clock: predict, advance, compare, then release single-cycle inputs.
    task automatic cyc();
        obs_t e, got;
        e = '0;
        model_step();
        for (int v = 0; v < NV; v++) begin
            e.busy[v] = ma[v];
            e.done[v] = mdn[v];
        end
        e.audio = maud;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {busy, done_stb, audio};
        e   = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL cycle t=%0t: got busy=%b done=%b audio=%b, want busy=%b done=%b audio=%b",
                     $time, got.busy, got.done, got.audio, e.busy, e.done, e.audio);
        end
        if (done_stb[1] === 1'b1) done1_cnt++;
        cmd_stb  = 1'b0;
        smp_tick = 1'b0;
        ms_tick  = 1'b0;
    endtask

    task automatic run(int n, bit st, bit mt);
        repeat (n) begin
            smp_tick = st;
            ms_tick  = mt;
            cyc();
        end
    endtask

    task automatic send(int v, int f, int m, int vl, int d, bit st, bit mt);
        cmd_stb   = 1'b1;
        cmd_voice = VIW'(v);
        cmd_freq  = PHW'(f);
        cmd_mode  = 2'(m);
        cmd_vol   = 4'(vl);
        cmd_dur   = DURW'(d);
        smp_tick  = st;
        ms_tick   = mt;
        cyc();
    endtask

    initial begin
        vec_t tbl[10];
        int   quiet;
        int   ones;

        tbl[0] = '{mode: 0, vol: 15, freq: 'h0100, nticks: 128, ones: 239};
        tbl[1] = '{mode: 0, vol: 15, freq: 'h0100, nticks: 127, ones: 0};
        tbl[2] = '{mode: 1, vol: 8,  freq: 'h1234, nticks: 1,   ones: 9};
        tbl[3] = '{mode: 1, vol: 15, freq: 'h0100, nticks: 200, ones: 187};
        tbl[4] = '{mode: 2, vol: 15, freq: 'h0100, nticks: 64,  ones: 120};
        tbl[5] = '{mode: 2, vol: 15, freq: 'h0100, nticks: 192, ones: 119};
        tbl[6] = '{mode: 3, vol: 15, freq: 'h0100, nticks: 128, ones: 0};
        tbl[7] = '{mode: 0, vol: 0,  freq: 'h0100, nticks: 128, ones: 0};
        tbl[8] = '{mode: 0, vol: 1,  freq: 'h0100, nticks: 128, ones: 15};
        tbl[9] = '{mode: 1, vol: 15, freq: 'h8001, nticks: 2,   ones: 0};

        rst = 1'b1; smp_tick = 1'b0; ms_tick = 1'b0; cmd_stb = 1'b0;
        cmd_voice = '0; cmd_freq = '0; cmd_mode = '0; cmd_vol = '0; cmd_dur = '0;

        // Reset, then a long idle stretch must stay silent
        run(3, 1'b0, 1'b0);
        check("cmd_rdy_in_reset", int'(cmd_rdy), 0);
        rst = 1'b0;
        #1;
        check("cmd_rdy_after_reset", int'(cmd_rdy), 1);
        quiet = 0;
        repeat (10000) begin
            run(1, 1'b1, 1'b1);
            if (busy != 0 || done_stb != 0 || audio != 1'b0) quiet++;
        end
        check("idle_quiet", quiet, 0);

        // Waveform/volume vectors on voice 0, voice 1 stopped
        send(1, 0, 0, 0, 0, 1'b0, 1'b0);
        foreach (tbl[i]) begin
            send(0, tbl[i].freq, tbl[i].mode, tbl[i].vol, 0, 1'b0, 1'b0);
            run(tbl[i].nticks, 1'b1, 1'b0);
            run(3, 1'b0, 1'b0);
            ones = 0;
            repeat (MSUM) begin
                run(1, 1'b0, 1'b0);
                ones += int'(audio);
            end
            check($sformatf("vec%0d_density", i), ones, tbl[i].ones);
        end

        // Duration expiry on voice 1 while voice 0 keeps playing
        send(0, 'h0100, 0, 15, 0, 1'b0, 1'b0);
        send(1, 'h0300, 1, 8, 3, 1'b0, 1'b0);
        done1_cnt = 0;
        for (int k = 1; k <= 3; k++) begin
            run(5, 1'b1, 1'b0);
            run(1, 1'b1, 1'b1);
            if (k == 2) check("busy1_after_2ms", int'(busy[1]), 1);
        end
        check("busy1_fall", int'(busy[1]), 0);
        check("done1_pulse", int'(done_stb[1]), 1);
        run(10, 1'b1, 1'b0);
        check("done1_once", done1_cnt, 1);
        check("busy0_kept", int'(busy[0]), 1);

        // Expiry and retrigger in the same cycle: command wins
        send(1, 'h0300, 1, 8, 1, 1'b0, 1'b0);
        run(4, 1'b1, 1'b0);
        done1_cnt = 0;
        send(1, 'h0500, 2, 12, 5, 1'b0, 1'b1);
        check("retrig_busy", int'(busy[1]), 1);
        check("retrig_no_done", int'(done_stb[1]), 0);
        check("retrig_phase0", int'(dut.phase[1]), 0);
        run(10, 1'b1, 1'b0);
        check("retrig_no_done_later", done1_cnt, 0);

        // Stop by zero frequency, and an out-of-range voice index
        send(0, 0, 0, 15, 0, 1'b0, 1'b0);
        check("stop_busy0", int'(busy[0]), 0);
        check("stop_no_done", int'(done_stb[0]), 0);
        send(2, 'h0100, 0, 15, 0, 1'b0, 1'b0);
        check("bad_voice_busy", int'(busy), 2);
        check("bad_voice_freq0", int'(dut.freq[0]), 0);
        run(5, 1'b1, 1'b0);

        // Reset pulse in the middle of a tone
        send(0, 'h0100, 0, 15, 0, 1'b0, 1'b0);
        run(40, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("cmd_rdy_mid_reset", int'(cmd_rdy), 0);
        cyc();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done_stb), 0);
        check("rst_audio", int'(audio), 0);
        check("rst_acc", int'(dut.acc), 0);
        check("rst_mix", int'(dut.mix), 0);
        rst = 1'b0;
        #1;
        check("cmd_rdy_post_reset", int'(cmd_rdy), 1);
        run(5, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
